// File: rtl/my_iris_pkg.sv
// Shared types and defaults for the modulation ramp generator family.
package my_iris_pkg;

   localparam int DEF_DAC_BIT  = 16;
   localparam int DEF_MIN_HALF = 2;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      MOD_H = 2'd1,
      MOD_L = 2'd2
   } mod_state_t;

endpackage

// File: rtl/my_half_period_cnt.sv
// Half-period timer: counts clocks since restart and flags the last cycle of a half.
module my_half_period_cnt #(
   parameter int W        = 32,
   parameter int MIN_HALF = 2
) (
   input  logic         i_clk,
   input  logic         i_rst,
   input  logic         i_active,
   input  logic         i_restart,
   input  logic [W-1:0] i_half,
   output logic         o_boundary
);

   logic [W-1:0] cnt_q;
   logic [W-1:0] cnt_d;
   logic [W-1:0] eff_half;

   // >= rather than == so a shrinking half ends at once instead of wrapping.
   always_comb begin
      eff_half   = (i_half < W'(MIN_HALF)) ? W'(MIN_HALF) : i_half;
      o_boundary = i_active && (cnt_q >= (eff_half - W'(1)));
      cnt_d      = i_restart ? '0 : (cnt_q + W'(1));
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/my_mod_ramp_gen_v1.sv
// Square-wave bias modulation plus closed-loop staircase ramp for the phase modulator DAC.
module my_mod_ramp_gen_v1
   import my_iris_pkg::*;
#(
   parameter int DAC_BIT  = DEF_DAC_BIT,
   parameter int MIN_HALF = DEF_MIN_HALF
) (
   input  logic                      i_clk,
   input  logic                      i_rst,
   input  logic                      i_en,
   input  logic [31:0]               i_half_cnt,
   input  logic signed [DAC_BIT-1:0] i_mod_high,
   input  logic signed [DAC_BIT-1:0] i_mod_low,
   input  logic signed [31:0]        i_step,
   input  logic                      i_step_sync,
   input  logic                      i_ramp_sync,
   output logic                      o_status,
   output logic                      o_trig,
   output logic signed [DAC_BIT-1:0] o_dac,
   output logic signed [31:0]        o_ramp,
   output logic [1:0]                o_cstate
);

   mod_state_t         state_q, state_d;
   logic [31:0]        ramp_q, ramp_d;
   logic [31:0]        step_q, step_d;
   logic               pending_q, pending_d;
   logic               status_q, status_d;
   logic               trig_q, trig_d;
   logic [DAC_BIT-1:0] dac_q, dac_d;

   logic               boundary;
   logic               restart;
   logic               apply;
   logic [31:0]        step_val;
   logic [DAC_BIT-1:0] level;

   my_half_period_cnt #(
      .W        (32),
      .MIN_HALF (MIN_HALF)
   ) u_half_cnt (
      .i_clk      (i_clk),
      .i_rst      (i_rst),
      .i_active   (state_q != IDLE),
      .i_restart  (restart),
      .i_half     (i_half_cnt),
      .o_boundary (boundary)
   );

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (i_en) state_d = MOD_H;
         MOD_H:   if (boundary) state_d = MOD_L;
         MOD_L:   if (boundary) state_d = MOD_H;
         default: state_d = IDLE;
      endcase
      if (!i_en) state_d = IDLE;

      restart = (state_d != state_q) || (state_d == IDLE);

      // Simultaneous syncs: the fresh step bypasses the register.
      step_val = i_step_sync ? i_step : step_q;
      apply    = boundary && (pending_q || i_ramp_sync);

      step_d    = i_step_sync ? i_step : step_q;
      ramp_d    = apply ? (ramp_q + step_val) : ramp_q;
      pending_d = apply ? 1'b0 : (pending_q || i_ramp_sync);
      if (!i_en) begin
         step_d    = '0;
         ramp_d    = '0;
         pending_d = 1'b0;
      end

      status_d = (state_d == MOD_H);
      trig_d   = (state_d != state_q) && (state_d != IDLE);
      level    = status_d ? i_mod_high : i_mod_low;
      dac_d    = (state_d == IDLE) ? '0 : (ramp_d[31 -: DAC_BIT] + level);
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state_q   <= IDLE;
         ramp_q    <= '0;
         step_q    <= '0;
         pending_q <= 1'b0;
         status_q  <= 1'b0;
         trig_q    <= 1'b0;
         dac_q     <= '0;
      end else begin
         state_q   <= state_d;
         ramp_q    <= ramp_d;
         step_q    <= step_d;
         pending_q <= pending_d;
         status_q  <= status_d;
         trig_q    <= trig_d;
         dac_q     <= dac_d;
      end
   end

   assign o_status = status_q;
   assign o_trig   = trig_q;
   assign o_dac    = dac_q;
   assign o_ramp   = ramp_q;
   assign o_cstate = state_q;

endmodule

// File: tb/tb_my_mod_ramp_gen_v1.sv
// Directed bench for my_mod_ramp_gen_v1: modulation timing, ramp apply rules, reset and idle.
module tb_my_mod_ramp_gen_v1;

   logic        clk;
   logic        rst;
   logic        en;
   logic [31:0] half_cnt;
   logic [15:0] mod_high;
   logic [15:0] mod_low;
   logic [31:0] step;
   logic        step_sync;
   logic        ramp_sync;
   logic        status;
   logic        trig;
   logic [15:0] dac;
   logic [31:0] ramp;
   logic [1:0]  cstate;

   int total = 0;
   int bad   = 0;

   logic [31:0] exp_ramp;
   logic        exp_status;
   logic [15:0] exp_dac;

   my_mod_ramp_gen_v1 dut (
      .i_clk       (clk),
      .i_rst       (rst),
      .i_en        (en),
      .i_half_cnt  (half_cnt),
      .i_mod_high  (mod_high),
      .i_mod_low   (mod_low),
      .i_step      (step),
      .i_step_sync (step_sync),
      .i_ramp_sync (ramp_sync),
      .o_status    (status),
      .o_trig      (trig),
      .o_dac       (dac),
      .o_ramp      (ramp),
      .o_cstate    (cstate)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #1000000;
      bad++;
      $display("FAIL watchdog: observed=timeout expected=finish");
      $display("test done: total=%0d bad=%0d", total, bad);
      $fatal(1, "watchdog expired");
   end

   task automatic tick(input int n = 1);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   initial begin
      rst       = 1'b1;
      en        = 1'b0;
      half_cnt  = 32'd100;
      mod_high  = 16'd1000;
      mod_low   = 16'hFC18;
      step      = '0;
      step_sync = 1'b0;
      ramp_sync = 1'b0;
      #2;
      chk("rst_status", 32'(status), 32'd0);
      chk("rst_trig",   32'(trig),   32'd0);
      chk("rst_dac",    32'(dac),    32'd0);
      chk("rst_ramp",   ramp,        32'd0);
      chk("rst_cstate", 32'(cstate), 32'd0);
      tick();
      rst = 1'b0;
      tick();
      chk("idle_cstate", 32'(cstate), 32'd0);

      // Plain modulation, 100-clock halves
      en = 1'b1;
      tick();
      chk("t1_entry_status", 32'(status), 32'd1);
      chk("t1_entry_trig",   32'(trig),   32'd1);
      chk("t1_entry_dac",    32'(dac),    32'd1000);
      chk("t1_entry_cstate", 32'(cstate), 32'd1);
      tick();
      chk("t1_trig_drop", 32'(trig), 32'd0);
      tick(98);
      chk("t1_h_last_status", 32'(status), 32'd1);
      chk("t1_h_last_trig",   32'(trig),   32'd0);
      tick();
      chk("t1_l_status", 32'(status), 32'd0);
      chk("t1_l_trig",   32'(trig),   32'd1);
      chk("t1_l_dac",    32'(dac),    32'h0000FC18);
      chk("t1_l_cstate", 32'(cstate), 32'd2);
      tick(99);
      chk("t1_l_last_status", 32'(status), 32'd0);
      tick();
      chk("t1_h2_status", 32'(status), 32'd1);
      chk("t1_h2_trig",   32'(trig),   32'd1);
      chk("t1_h2_dac",    32'(dac),    32'd1000);
      chk("t1_ramp",      ramp,        32'd0);

      // Halves clamp to 2 clocks for half_cnt 0 and 1
      half_cnt = 32'd0;
      tick();
      chk("t2_h0_a_status", 32'(status), 32'd1);
      chk("t2_h0_a_trig",   32'(trig),   32'd0);
      tick();
      chk("t2_h0_b_status", 32'(status), 32'd0);
      chk("t2_h0_b_trig",   32'(trig),   32'd1);
      tick();
      chk("t2_h0_c_trig", 32'(trig), 32'd0);
      tick();
      chk("t2_h0_d_status", 32'(status), 32'd1);
      chk("t2_h0_d_trig",   32'(trig),   32'd1);
      half_cnt = 32'd1;
      tick();
      chk("t2_h1_a_status", 32'(status), 32'd1);
      chk("t2_h1_a_trig",   32'(trig),   32'd0);
      tick();
      chk("t2_h1_b_status", 32'(status), 32'd0);
      chk("t2_h1_b_trig",   32'(trig),   32'd1);
      tick();
      tick();
      chk("t2_h1_d_status", 32'(status), 32'd1);
      chk("t2_h1_d_trig",   32'(trig),   32'd1);

      // Ramp applies only at boundaries; 16 x 0x1000_0000 wraps to 0
      half_cnt  = 32'd10;
      step      = 32'h1000_0000;
      step_sync = 1'b1;
      tick();
      step_sync = 1'b0;
      ramp_sync = 1'b1;
      tick();
      ramp_sync = 1'b0;
      chk("t3_mid_half_ramp", ramp, 32'd0);
      tick(7);
      chk("t3_last_cycle_ramp", ramp, 32'd0);
      tick();
      exp_ramp   = 32'h1000_0000;
      exp_status = 1'b0;
      chk("t3_apply1_ramp",   ramp,        exp_ramp);
      chk("t3_apply1_status", 32'(status), 32'd0);
      chk("t3_apply1_dac",    32'(dac),    32'd3096);
      for (int k = 2; k <= 16; k++) begin
         ramp_sync = 1'b1;
         tick();
         ramp_sync = 1'b0;
         tick(9);
         exp_ramp   = exp_ramp + 32'h1000_0000;
         exp_status = ~exp_status;
         exp_dac    = exp_ramp[31:16] + (exp_status ? mod_high : mod_low);
         chk("t3_loop_ramp",   ramp,        exp_ramp);
         chk("t3_loop_status", 32'(status), 32'(exp_status));
         chk("t3_loop_dac",    32'(dac),    32'(exp_dac));
      end
      chk("t3_wrap_ramp", ramp,     32'd0);
      chk("t3_wrap_dac",  32'(dac), 32'd1000);

      // Simultaneous syncs use the fresh step; repeated requests apply once
      step      = 32'd3;
      step_sync = 1'b1;
      tick();
      step_sync = 1'b0;
      tick(8);
      step      = 32'd5;
      step_sync = 1'b1;
      ramp_sync = 1'b1;
      tick();
      step_sync = 1'b0;
      ramp_sync = 1'b0;
      chk("t4_bypass_ramp", ramp,     32'd5);
      chk("t4_bypass_dac",  32'(dac), 32'h0000FC18);
      ramp_sync = 1'b1;
      tick();
      ramp_sync = 1'b0;
      tick();
      ramp_sync = 1'b1;
      tick(2);
      ramp_sync = 1'b0;
      tick(5);
      chk("t4_no_mid_apply", ramp, 32'd5);
      tick();
      chk("t4_single_apply", ramp,       32'd10);
      chk("t4_edge_trig",    32'(trig),  32'd1);
      tick(10);
      chk("t4_no_second_apply", ramp, 32'd10);

      // Mid-half shrink ends the half on the next clock
      half_cnt = 32'd100;
      tick(50);
      half_cnt = 32'd10;
      chk("t5_before_status", 32'(status), 32'd0);
      tick();
      chk("t5_shrink_status", 32'(status), 32'd1);
      chk("t5_shrink_trig",   32'(trig),   32'd1);
      tick();
      chk("t5_trig_single", 32'(trig), 32'd0);
      tick(8);
      chk("t5_h_last_status", 32'(status), 32'd1);
      tick();
      chk("t5_l_status", 32'(status), 32'd0);
      chk("t5_l_trig",   32'(trig),   32'd1);
      chk("t5_ramp",     ramp,        32'd10);

      // Async reset mid MOD_L with a pending request
      ramp_sync = 1'b1;
      tick();
      ramp_sync = 1'b0;
      tick(3);
      rst = 1'b1;
      #1;
      chk("t6_rst_status", 32'(status), 32'd0);
      chk("t6_rst_trig",   32'(trig),   32'd0);
      chk("t6_rst_dac",    32'(dac),    32'd0);
      chk("t6_rst_ramp",   ramp,        32'd0);
      chk("t6_rst_cstate", 32'(cstate), 32'd0);
      tick();
      rst = 1'b0;
      tick();
      chk("t6_restart_status", 32'(status), 32'd1);
      chk("t6_restart_trig",   32'(trig),   32'd1);
      chk("t6_restart_ramp",   ramp,        32'd0);
      step      = 32'd7;
      step_sync = 1'b1;
      tick();
      step_sync = 1'b0;
      tick(8);
      tick();
      chk("t6_no_stale_ramp", ramp,     32'd0);
      chk("t6_no_stale_dac",  32'(dac), 32'h0000FC18);

      // Live modulation update, then i_en=0 clears everything
      ramp_sync = 1'b1;
      tick();
      ramp_sync = 1'b0;
      tick(8);
      tick();
      chk("t7_apply_ramp", ramp,     32'd7);
      chk("t7_apply_dac",  32'(dac), 32'd1000);
      mod_high = 16'd2000;
      tick();
      chk("t7_live_mod_dac", 32'(dac), 32'd2000);
      en = 1'b0;
      tick();
      chk("t7_idle_cstate", 32'(cstate), 32'd0);
      chk("t7_idle_ramp",   ramp,        32'd0);
      chk("t7_idle_dac",    32'(dac),    32'd0);
      chk("t7_idle_status", 32'(status), 32'd0);
      chk("t7_idle_trig",   32'(trig),   32'd0);
      en = 1'b1;
      tick();
      chk("t7_reentry_status", 32'(status), 32'd1);
      chk("t7_reentry_trig",   32'(trig),   32'd1);
      chk("t7_reentry_dac",    32'(dac),    32'd2000);
      chk("t7_reentry_ramp",   ramp,        32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/my_mod_ramp_gen_v1.md
Name: my_mod_ramp_gen_v1

Overview:
- Drives the phase modulator DAC with the square-wave bias modulation plus the closed-loop staircase ramp.
- Produces o_status and o_trig, which the error signal generator consumes as its modulation-state and transition inputs.
- Consumes the error generator's step and ramp syncs, and accumulates the loop step into the ramp.
- Sits between the loop integrator/error generator and the modulator DAC interface.

Parameters:
DAC_BIT, 16, DAC word width; o_dac is the signed DAC code.
MIN_HALF, 2, minimum accepted half-period in clocks.

Ports:
i_clk  in  1  system clock
i_rst  in  1  asynchronous, active-high reset
i_en  in  1  run enable; 0 forces the IDLE state
i_half_cnt  in  32  modulation half-period in clocks (unsigned)
i_mod_high  in  DAC_BIT  signed DAC offset in the high half
i_mod_low  in  DAC_BIT  signed DAC offset in the low half
i_step  in  32  signed ramp increment from the loop
i_step_sync  in  1  pulse: latch i_step into step_reg
i_ramp_sync  in  1  pulse: request ramp += step_reg
o_status  out  1  1 = high half, 0 = low half
o_trig  out  1  one-clock pulse on every modulation edge
o_dac  out  DAC_BIT  signed DAC code
o_ramp  out  32  signed ramp accumulator (debug)
o_cstate  out  2  current state (debug)

Behaviour:
- Reset (async on i_rst=1) and IDLE values:
  - o_status=0, o_trig=0, o_dac=0, o_ramp=0.
  - step_reg=0, pending=0, half counter=0, cstate=IDLE.
- States and transitions:
  - IDLE: exit to MOD_H when i_en=1.
  - MOD_H: go to MOD_L at the boundary.
  - MOD_L: go to MOD_H at the boundary.
  - Any state: i_en=0 returns to IDLE on the next clock. The ramp and step_reg are cleared, as at reset.
- Half-period counter:
  - eff_half = max(i_half_cnt, MIN_HALF), sampled live each cycle.
  - The counter clears on state entry and increments each clock.
  - Boundary cycle: counter >= eff_half-1. Using >= means a mid-period shrink of i_half_cnt ends the half immediately rather than wrapping.
- Output timing, for the cycle after each boundary and after IDLE->MOD_H entry:
  - o_status shows the new half.
  - o_trig=1 for exactly one clock.
  - o_dac shows the new level.
  - Every half lasts exactly eff_half clocks.
- Step latch: i_step_sync=1 -> step_reg <= i_step on the next clock.
- Ramp request:
  - i_ramp_sync=1 sets pending.
  - A second request while pending is already set is absorbed: one apply only.
- Ramp apply:
  - On a boundary cycle with pending=1 (or i_ramp_sync=1 in that same cycle): ramp <= ramp + step_val and pending clears.
  - step_val is i_step if i_step_sync=1 in that cycle, else step_reg (bypass for simultaneous syncs).
  - The ramp therefore changes only together with a modulation edge, so there is no mid-half glitch.
- Ramp arithmetic: 32-bit two's complement with natural wrap-around (the 2π reset); no saturation.
- DAC code, registered on every clock, so the o_dac latency to a ramp change is 1 clock after the boundary:
  - o_dac = ramp[31 -: DAC_BIT] + (o_status-to-be ? i_mod_high : i_mod_low).
  - Sum is modulo 2^DAC_BIT (wraps, no clamp).
  - i_mod_high/i_mod_low changes appear on o_dac within 1 clock, even mid-half.
- Reset mid-operation: all outputs return to reset values immediately; pending requests are discarded.
- Downstream error generator usage: it starts in the high half and takes o_trig at the H->L edge as the start of its low acquisition. Both edges pulse o_trig.

Decomposition:
- Shared package my_iris_pkg: state typedef mod_state_t {IDLE=2'd0, MOD_H=2'd1, MOD_L=2'd2}, MIN_HALF constant, DAC_BIT default.
- One natural sub-module: my_half_period_cnt. It holds the counter, the eff_half clamp and the boundary pulse, and is reusable for other modulation timers.
- The ramp/DAC datapath stays in the top module.

Test Plan:
1. Reset, then i_en=1, i_half_cnt=100, i_mod_high=+1000, i_mod_low=-1000, no syncs -> o_status period 200 clocks, 50% duty; o_trig pulses exactly every 100 clocks; o_dac alternates +1000/-1000; o_ramp=0.
2. i_half_cnt=0 and =1 -> each half lasts 2 clocks; o_trig at every other clock; no lockup.
3. i_step=0x1000_0000: step_sync, then ramp_sync mid-half -> o_ramp changes only at the next boundary; after 16 applies o_ramp wraps back to 0 and o_dac equals the bare modulation level.
4. i_step_sync and i_ramp_sync asserted in the same boundary cycle with i_step=5, step_reg=3 -> o_ramp increases by 5; three ramp_syncs within one half -> single apply.
5. i_half_cnt changed from 100 to 10 at count 50 -> that half ends the next clock; subsequent halves are 10 clocks; o_trig is still a single-clock pulse.
6. Assert i_rst for 1 clock mid MOD_L with pending=1 and o_ramp≠0 -> all outputs 0 asynchronously; after release, MOD_H restarts with o_ramp=0 and no stale ramp apply.
